inst_mem_prog: RTL and testbench
================================

// Module: inst_mem_prog
// PURPOSE
//   Parametrised instruction memory for the fetch stage.
//   - Words are DATA_W bits wide; DEPTH entries, addressed by ADDR_W bits.
//   - Reads are registered with a req/valid handshake.
//   - A write (programming) port loads programs at run time; a sticky lock bit write-protects the array.
//   - Reset restores a built-in marker pattern, so the fetch stage always has a defined program.
// PARAMETERS
//   ADDR_W      4    address width
//   DEPTH       16   number of words, 2 <= DEPTH <= 2**ADDR_W
//   DATA_W      8    instruction word width, >= 1
//   MARK_PERIOD 4    reset pattern: word i = 1 if i%MARK_PERIOD==MARK_PERIOD-1, else 0 (>= 1)
// PORTS
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous reset, active low
//   fetch_req   in   1       read request, sampled each rising edge
//   fetch_addr  in   ADDR_W  read address
//   fetch_valid out  1       fetch_data/fetch_err valid this cycle
//   fetch_data  out  DATA_W  read word
//   fetch_err   out  1       addressed word out of range (addr >= DEPTH)
//   prog_en     in   1       write strobe
//   prog_addr   in   ADDR_W  write address
//   prog_data   in   DATA_W  write data
//   prog_lock   in   1       sets sticky lock; cleared only by reset
//   locked      out  1       lock state
//   prog_err    out  1       one-cycle pulse: write rejected
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//   - fetch_valid=0, fetch_data=0, fetch_err=0, locked=0, prog_err=0.
//   - Array reloads the marker pattern immediately.
//   - Any in-flight read is dropped; no valid is produced after reset release for a pre-reset request.
//   Read:
//   - fetch_req=1 at edge N -> at edge N+1: fetch_valid=1, fetch_data=mem[fetch_addr sampled at N].
//   - Fully pipelined: back-to-back requests give back-to-back valids. No backpressure.
//   - fetch_req=0 at edge N -> fetch_valid=0 after edge N+1; fetch_data holds its last value.
//   - fetch_addr >= DEPTH: fetch_valid=1, fetch_err=1, fetch_data=0.
//   - fetch_err=0 on every valid in-range read.
//   Write:
//   - prog_en=1 at edge N, not locked, prog_addr < DEPTH: mem[prog_addr]<=prog_data at edge N.
//   - Rejected writes (locked, or prog_addr >= DEPTH): array unchanged; prog_err=1 for the cycle after edge N.
//   Read/write collision:
//   - Same-edge read and write to the same address: read returns OLD data (read-before-write).
//   - The next read of that address returns the new data.
//   Lock:
//   - prog_lock=1 at edge N -> locked=1 from edge N.
//   - A write at the same edge N as prog_lock is still accepted.
//   - Writes from edge N+1 are rejected.
//   - Lock is idempotent; only rst_n clears it.
//   Width rules:
//   - Pattern word "1" is zero-extended to DATA_W.
//   - Addresses are unsigned; no wrap-around of out-of-range addresses.
// TESTING (ADDR_W=4, DEPTH=12, DATA_W=8, MARK_PERIOD=4)
//   1. Reset, read addr 0..11 back-to-back
//      -> 0x01 at 3, 7, 11 and 0x00 elsewhere; valid every cycle, 1-cycle latency.
//   2. Write 0xA5 @5, then read 5
//      -> 0xA5, fetch_err=0; same-edge write 0x3C @5 + read 5 -> 0xA5, next read -> 0x3C.
//   3. Read addr 13
//      -> fetch_valid=1, fetch_err=1, fetch_data=0x00.
//      Write @14 -> prog_err pulse, array unchanged.
//   4. prog_lock + write 0x77 @2 same edge -> accepted.
//      Write 0x88 @2 next cycle -> prog_err=1; read 2 -> 0x77; locked stays 1.
//   5. Assert rst_n=0 mid-stream, with a read pending and locked=1
//      -> outputs zero immediately, locked=0, word 2 back to 0x00, word 3 back to 0x01.

Source files
------------

// File: rtl/inst_mem_prog.sv
// ---------------------------------------------------------------------------
// inst_mem_prog
//   Instruction memory for the fetch stage. Registered reads with a
//   req/valid handshake, a run-time programming port, and a sticky lock
//   that write-protects the array until the next reset. Reset reloads a
//   marker pattern (word i = 1 when i % MARK_PERIOD == MARK_PERIOD-1),
//   so the fetch stage always sees a defined program.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   fetch_req/addr      read request and address, sampled each edge
//   fetch_valid         read result valid (1-cycle latency, pipelined)
//   fetch_data          read word; holds its value when no request
//   fetch_err           address was >= DEPTH (data forced to 0)
//   prog_en/addr/data   write strobe, address and data
//   prog_lock           sets the sticky lock
//   locked              current lock state
//   prog_err            one-cycle pulse for a rejected write
// ---------------------------------------------------------------------------
module inst_mem_prog #(
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 8,
    parameter int MARK_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_lock,
    output logic              locked,
    output logic              prog_err
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    function automatic logic [DATA_W-1:0] mark_word(input int idx);
        return ((idx % MARK_PERIOD) == (MARK_PERIOD - 1)) ? DATA_W'(1) : '0;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q,  fetch_data_d;
    logic              fetch_err_q,   fetch_err_d;
    logic              locked_q,      locked_d;
    logic              prog_err_q,    prog_err_d;

    logic              fetch_in_range;
    logic              prog_in_range;
    logic              write_ok;
    logic [DATA_W-1:0] rd_word;

    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_X);
    assign prog_in_range  = ({1'b0, prog_addr}  < DEPTH_X);
    // Lock is checked against the registered state, so a write on the same
    // edge that raises prog_lock still lands.
    assign write_ok       = prog_en && !locked_q && prog_in_range;

    // Read mux over the old array contents: a same-edge write to the same
    // address is not visible to this read.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fetch_addr == ADDR_W'(i)) begin
                rd_word = mem_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (write_ok && (prog_addr == ADDR_W'(i))) begin
                mem_d[i] = prog_data;
            end
        end
    end

    always_comb begin
        fetch_valid_d = fetch_req;
        fetch_data_d  = fetch_data_q;
        fetch_err_d   = 1'b0;
        if (fetch_req) begin
            fetch_data_d = fetch_in_range ? rd_word : '0;
            fetch_err_d  = !fetch_in_range;
        end
        locked_d   = locked_q | prog_lock;
        prog_err_d = prog_en && !write_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mark_word(i);
            end
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_err_q   <= 1'b0;
            locked_q      <= 1'b0;
            prog_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_err_q   <= fetch_err_d;
            locked_q      <= locked_d;
            prog_err_q    <= prog_err_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_err   = fetch_err_q;
    assign locked      = locked_q;
    assign prog_err    = prog_err_q;

endmodule

// File: tb/tb_inst_mem_prog.sv
module tb_inst_mem_prog;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;
    localparam int DATA_W = 8;
    localparam int MARK   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;
    logic              prog_en = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;
    logic              prog_lock = 1'b0;
    logic              locked;
    logic              prog_err;

    inst_mem_prog #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MARK_PERIOD(MARK)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
        .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_lock(prog_lock), .locked(locked), .prog_err(prog_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mem [16];
    bit          m_locked;
    bit          m_valid;
    int          m_data;
    bit          m_ferr;
    bit          m_perr;

    function automatic int mark_of(input int i);
        return (i % MARK == MARK - 1) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = (i < DEPTH) ? mark_of(i) : 0;
            m_locked = 0; m_valid = 0; m_data = 0; m_ferr = 0; m_perr = 0;
        end else begin
            int fa, pa;
            fa = int'(fetch_addr);
            pa = int'(prog_addr);
            m_valid = fetch_req;
            if (fetch_req) begin
                m_ferr = (fa >= DEPTH);
                m_data = (fa >= DEPTH) ? 0 : m_mem[fa];
            end
            m_perr = 0;
            if (prog_en) begin
                if (!m_locked && pa < DEPTH) m_mem[pa] = int'(prog_data);
                else m_perr = 1;
            end
            if (prog_lock) m_locked = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", 32'(fetch_valid), 32'(m_valid));
            chk("data", 32'(fetch_data), 32'(m_data));
            if (m_valid) chk("ferr", 32'(fetch_err), 32'(m_ferr));
            chk("locked", 32'(locked), 32'(m_locked));
            chk("perr", 32'(prog_err), 32'(m_perr));
        end
    end

    // Drive one cycle's inputs, pass the edge, return 2 time units later.
    task automatic cyc(input bit req, input int fa, input bit en, input int pa,
                       input int pd, input bit lk);
        fetch_req  = req;
        fetch_addr = ADDR_W'(fa);
        prog_en    = en;
        prog_addr  = ADDR_W'(pa);
        prog_data  = DATA_W'(pd);
        prog_lock  = lk;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(fetch_valid), 0);
        chk("rst_data", 32'(fetch_data), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_perr", 32'(prog_err), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cmp_en = 1;

        // 1: marker pattern, back-to-back reads
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, i, 0, 0, 0, 0);
            chk($sformatf("pat_v%0d", i), 32'(fetch_valid), 1);
            chk($sformatf("pat_d%0d", i), 32'(fetch_data), (i % 4 == 3) ? 1 : 0);
        end
        idle();
        chk("idle_valid", 32'(fetch_valid), 0);

        // 2: write, read, collision
        cyc(0, 0, 1, 5, 8'hA5, 0);
        cyc(1, 5, 0, 0, 0, 0);
        chk("wr5_data", 32'(fetch_data), 32'hA5);
        chk("wr5_err", 32'(fetch_err), 0);
        cyc(1, 5, 1, 5, 8'h3C, 0);
        chk("coll_old", 32'(fetch_data), 32'hA5);
        cyc(1, 5, 0, 0, 0, 0);
        chk("coll_new", 32'(fetch_data), 32'h3C);

        // 3: out-of-range read and write
        cyc(1, 13, 0, 0, 0, 0);
        chk("oor_valid", 32'(fetch_valid), 1);
        chk("oor_err", 32'(fetch_err), 1);
        chk("oor_data", 32'(fetch_data), 0);
        cyc(0, 0, 1, 14, 8'hFF, 0);
        chk("oor_perr", 32'(prog_err), 1);
        idle();
        chk("perr_pulse", 32'(prog_err), 0);

        // 4: lock with same-edge write
        cyc(0, 0, 1, 2, 8'h77, 1);
        chk("lock_set", 32'(locked), 1);
        chk("lock_wr_ok", 32'(prog_err), 0);
        cyc(0, 0, 1, 2, 8'h88, 0);
        chk("lock_rej", 32'(prog_err), 1);
        cyc(1, 2, 0, 0, 0, 1);
        chk("lock_rd2", 32'(fetch_data), 32'h77);
        chk("lock_hold", 32'(locked), 1);

        // 5: reset mid-stream with a read pending and lock set
        cyc(1, 2, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(fetch_valid), 0);
        chk("mrst_data", 32'(fetch_data), 0);
        chk("mrst_locked", 32'(locked), 0);
        chk("mrst_perr", 32'(prog_err), 0);
        fetch_req = 0; prog_en = 0; prog_lock = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle();
        chk("post_rst_valid", 32'(fetch_valid), 0);
        cyc(1, 2, 0, 0, 0, 0);
        chk("post_rst_w2", 32'(fetch_data), 0);
        cyc(1, 3, 0, 0, 0, 0);
        chk("post_rst_w3", 32'(fetch_data), 1);
        chk("post_rst_unlocked", 32'(locked), 0);

        // Random traffic, periodic resets so the lock does not stick forever
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 150; c++) begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                    $urandom_range(0, 255), $urandom_range(0, 60) == 0);
            end
            #1 rst_n = 1'b0;
            fetch_req = 0; prog_en = 0; prog_lock = 0;
            @(posedge clk); #2;
            rst_n = 1'b1;
        end

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
